// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls, program-load write port and IF/ID outputs.
// The driver (control/loader) side uses master; the fetch stage itself uses slave.
interface fetch_stage_if #(
  parameter int unsigned IMEM_AW = 7
);
  logic               stall;
  logic               pcsrc;
  logic [31:0]        branch_target;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic [31:0]        pc;
  logic [31:0]        if_id_instr;
  logic [31:0]        if_id_npc;
  logic               if_id_valid;

  modport master (
    output stall, pcsrc, branch_target, imem_we, imem_waddr, imem_wdata,
    input  pc, if_id_instr, if_id_npc, if_id_valid
  );

  modport slave (
    input  stall, pcsrc, branch_target, imem_we, imem_waddr, imem_wdata,
    output pc, if_id_instr, if_id_npc, if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, word-addressed instruction memory and IF/ID register.
// Per-edge priority is rst > redirect > stall > fetch; memory writes are independent of all three.
module fetch_stage #(
  parameter int unsigned IMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.slave bus
);
  localparam logic [31:0] BUBBLE = 32'h8000_0000;

  logic [31:0] imem [0:(1 << IMEM_AW) - 1];
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_word;

  // Not reset: program contents survive rst. Reads below see pre-write data.
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  assign fetch_word = imem[pc_q[IMEM_AW+1:2]];
  assign pc_plus4   = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (bus.pcsrc) begin
      pc_d    = bus.branch_target & ~32'd3;
      instr_d = BUBBLE;
      npc_d   = '0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d    = pc_plus4;
      instr_d = fetch_word;
      npc_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= BUBBLE;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_npc   = npc_q;
  assign bus.if_id_valid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: program load, fetch, stall, redirect, reset, RAW on imem, PC wrap.
module tb_fetch_stage;
  logic clk;
  logic rst;
  logic rst2;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fetch_stage_if #(.IMEM_AW(7)) bus ();
  fetch_stage_if #(.IMEM_AW(7)) bus2 ();

  fetch_stage #(.IMEM_AW(7), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fetch_stage #(.IMEM_AW(7), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc_e,
                            input logic [31:0] ins_e, input logic [31:0] npc_e,
                            input logic val_e);
    check({tag, ".pc"},    bus.pc,                  pc_e);
    check({tag, ".instr"}, bus.if_id_instr,         ins_e);
    check({tag, ".npc"},   bus.if_id_npc,           npc_e);
    check({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, val_e});
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = d;
    tick();
    bus.imem_we    = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus.pcsrc         = 1'b1;
    bus.branch_target = tgt;
    tick();
    bus.pcsrc         = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  rst2 = 1'b1;
    bus.stall = 1'b0;  bus.pcsrc = 1'b0;  bus.branch_target = '0;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
    bus2.stall = 1'b0; bus2.pcsrc = 1'b0; bus2.branch_target = '0;
    bus2.imem_we = 1'b1; bus2.imem_waddr = '0; bus2.imem_wdata = 32'hCAFE_0001;

    // Program load happens while held in reset
    wr(7'd0, 32'h8C01_0004);
    bus2.imem_we = 1'b0;
    wr(7'd1, 32'h0022_1820);
    wr(7'd2, 32'hAC03_0008);
    wr(7'd3, 32'h1000_0002);
    wr(7'd5, 32'h5555_5555);
    wr(7'd8, 32'h1234_5678);
    check_ifid("reset", 32'h0, 32'h8000_0000, 32'h0, 1'b0);
    check("reset2.pc", bus2.pc, 32'hFFFF_FFFC);

    // Sequential fetch of words 0..3, plus the wrapping instance alongside
    rst = 1'b0; rst2 = 1'b0;
    tick();
    check_ifid("fetch1", 32'd4, 32'h8C01_0004, 32'd4, 1'b1);
    check("wrap.pc",    bus2.pc,                  32'h0);
    check("wrap.npc",   bus2.if_id_npc,           32'h0);
    check("wrap.valid", {31'd0, bus2.if_id_valid}, 32'd1);
    tick();
    check_ifid("fetch2", 32'd8, 32'h0022_1820, 32'd8, 1'b1);
    check("wrap2.instr", bus2.if_id_instr, 32'hCAFE_0001);
    check("wrap2.npc",   bus2.if_id_npc,   32'd4);
    tick();
    check_ifid("fetch3", 32'd12, 32'hAC03_0008, 32'd12, 1'b1);
    tick();
    check_ifid("fetch4", 32'd16, 32'h1000_0002, 32'd16, 1'b1);

    // Back to word 1, then stall three cycles
    redirect(32'd4);
    check_ifid("redir4", 32'd4, 32'h8000_0000, 32'd0, 1'b0);
    tick();
    check_ifid("word1", 32'd8, 32'h0022_1820, 32'd8, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ifid("stall", 32'd8, 32'h0022_1820, 32'd8, 1'b1);
    end
    bus.stall = 1'b0;
    tick();
    check_ifid("resume", 32'd12, 32'hAC03_0008, 32'd12, 1'b1);

    // Redirect beats stall; low target bits dropped
    bus.stall = 1'b1;
    redirect(32'h0000_0023);
    bus.stall = 1'b0;
    check_ifid("redir_stall", 32'h20, 32'h8000_0000, 32'd0, 1'b0);
    tick();
    check_ifid("word8", 32'h24, 32'h1234_5678, 32'h24, 1'b1);

    // Back-to-back redirects
    bus.pcsrc = 1'b1; bus.branch_target = 32'h10;
    tick();
    check("b2b1.pc", bus.pc, 32'h10);
    redirect(32'h14);
    check_ifid("b2b2", 32'h14, 32'h8000_0000, 32'd0, 1'b0);

    // Write and fetch word 5 on the same edge: old data
    wr(7'd5, 32'hDEAD_BEEF);
    check_ifid("raw_old", 32'h18, 32'h5555_5555, 32'h18, 1'b1);
    redirect(32'h14);
    tick();
    check_ifid("raw_new", 32'h18, 32'hDEAD_BEEF, 32'h18, 1'b1);

    // Reset mid-program overrides redirect and stall
    redirect(32'd12);
    check("pre_rst.pc", bus.pc, 32'd12);
    rst = 1'b1; bus.pcsrc = 1'b1; bus.branch_target = 32'h40; bus.stall = 1'b1;
    tick();
    check_ifid("mid_rst", 32'h0, 32'h8000_0000, 32'd0, 1'b0);
    rst = 1'b0; bus.pcsrc = 1'b0; bus.stall = 1'b0;
    tick();
    check_ifid("post_rst1", 32'd4, 32'h8C01_0004, 32'd4, 1'b1);
    tick();
    check_ifid("post_rst2", 32'd8, 32'h0022_1820, 32'd8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
